// File: rtl/mult_result_display_if.sv
// Operand/product inputs and seven-segment display outputs of the
// multiplier display stage.
interface mult_result_display_if;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] product;
    logic       carry;
    logic       load;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       valid;

    modport master (
        output a, b, product, carry, load,
        input  seg, an, dp, valid
    );

    modport slave (
        input  a, b, product, carry, load,
        output seg, an, dp, valid
    );
endinterface

// File: rtl/mult_result_display.sv
// Output stage for the 2x2 array multiplier: captures operands and product on a
// debounced button press and multiplexes them onto a 4-digit active-low display.
module mult_result_display #(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_result_display_if.slave bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int RCNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic              sync1_r;
    logic              sync2_r;
    logic              db_r;
    logic              db_prev_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [RCNT_W-1:0] rcnt_r;
    logic [1:0]        idx_r;
    logic [1:0]        reg_a_r;
    logic [1:0]        reg_b_r;
    logic [3:0]        reg_p_r;
    logic              valid_r;
    logic              capture_s;
    logic [6:0]        seg_s;
    logic [3:0]        an_s;

    // Digits 10..15 cannot be shown in decimal, so they display E.
    function automatic logic [6:0] seg_code(input logic [3:0] value);
        case (value)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b0000110;
        endcase
    endfunction

    assign capture_s = db_r & ~db_prev_r;

    // Two-flop synchronizer feeding a counting debouncer on the load button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            db_r      <= 1'b0;
            db_prev_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            sync1_r   <= bus.load;
            sync2_r   <= sync1_r;
            db_prev_r <= db_r;
            if (sync2_r == db_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                db_r  <= sync2_r;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Capture operands and product once per debounced rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a_r <= 2'd0;
            reg_b_r <= 2'd0;
            reg_p_r <= 4'd0;
            valid_r <= 1'b0;
        end else if (capture_s) begin
            reg_a_r <= bus.a;
            reg_b_r <= bus.b;
            reg_p_r <= {bus.carry, bus.product};
            valid_r <= 1'b1;
        end else begin
            reg_a_r <= reg_a_r;
            reg_b_r <= reg_b_r;
            reg_p_r <= reg_p_r;
            valid_r <= valid_r;
        end
    end

    // Refresh timer: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_r <= {RCNT_W{1'b0}};
            idx_r  <= 2'd0;
        end else if (rcnt_r == RCNT_LAST) begin
            rcnt_r <= {RCNT_W{1'b0}};
            idx_r  <= idx_r + 2'd1;
        end else begin
            rcnt_r <= rcnt_r + RCNT_W'(1);
            idx_r  <= idx_r;
        end
    end

    // Digit decode; leftmost digit is A, then B, blank, product.
    always_comb begin
        an_s  = ~(4'b0001 << idx_r);
        seg_s = SEG_DASH;
        if (valid_r) begin
            case (idx_r)
                2'd3:    seg_s = seg_code({2'b00, reg_a_r});
                2'd2:    seg_s = seg_code({2'b00, reg_b_r});
                2'd1:    seg_s = SEG_BLANK;
                2'd0:    seg_s = seg_code(reg_p_r);
                default: seg_s = SEG_DASH;
            endcase
        end else begin
            seg_s = SEG_DASH;
        end
    end

    assign bus.seg   = seg_s;
    assign bus.an    = an_s;
    assign bus.dp    = 1'b1;
    assign bus.valid = valid_r;
endmodule
